clk_div_ctrl: RTL and testbench

//   Runtime-programmable power-of-two clock divider controller. Produces a divided

---
 rtl/clk_div_pkg.sv | 20 ++
 rtl/clk_div_counter.sv | 40 ++++
 rtl/clk_div_ctrl.sv | 79 +++++++
 tb/tb_clk_div_ctrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the power-of-two clock divider controller.
package clk_div_pkg;

  localparam int SEL_W = 3;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    RUN    = 2'd1,
    SWITCH = 2'd2
  } state_e;

  // Terminal count of a divide-by-2^(sel+1) period.
  function automatic logic [CNT_W-1:0] last_count(input logic [SEL_W-1:0] sel);
    logic [31:0] n;
    n = (32'd2 << sel) - 32'd1;
    return n[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/clk_div_counter.sv
// Period counter with boundary detect and registered div_out / tick outputs.
module clk_div_counter
  import clk_div_pkg::*;
#(
  parameter int SEL_W = clk_div_pkg::SEL_W,
  parameter int CNT_W = clk_div_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [SEL_W-1:0] active_sel,
  output logic             boundary,
  output logic             div_out,
  output logic             tick
);

  logic [CNT_W-1:0] count;
  logic             at_last;

  assign at_last  = (count == last_count(active_sel));
  assign boundary = run && at_last;

  // NOTE: non-blocking assignments so every register here samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      div_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      if (!run || at_last) begin
        count <= '0;
      end else begin
        count <= count + CNT_W'(1);
      end
      div_out <= count[active_sel];
      tick    <= boundary;
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Divider control FSM: cfg handshake, pending ratio, and boundary-aligned switching.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int SEL_W   = clk_div_pkg::SEL_W,
  parameter int CNT_W   = clk_div_pkg::CNT_W,
  parameter int RST_SEL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [SEL_W-1:0] cfg_sel,
  output logic             cfg_ready,
  output logic [SEL_W-1:0] active_sel,
  output logic             div_out,
  output logic             tick,
  output logic             busy
);

  localparam logic [1:0] ST_OFF    = OFF;
  localparam logic [1:0] ST_RUN    = RUN;
  localparam logic [1:0] ST_SWITCH = SWITCH;

  logic [1:0]       state;
  logic [SEL_W-1:0] pending_sel;
  logic             boundary;
  logic             xfer;

  assign cfg_ready = (state != ST_SWITCH);
  assign busy      = (state != ST_OFF);
  assign xfer      = cfg_valid && cfg_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_OFF;
      active_sel  <= SEL_W'(RST_SEL);
      pending_sel <= '0;
    end else begin
      case (state)
        ST_OFF: begin
          if (xfer) active_sel <= cfg_sel;
          if (en)   state      <= ST_RUN;
        end
        ST_RUN: begin
          // A ratio accepted while running waits for the next boundary.
          if (xfer) begin
            pending_sel <= cfg_sel;
            state       <= ST_SWITCH;
          end else if (boundary && !en) begin
            state <= ST_OFF;
          end
        end
        ST_SWITCH: begin
          if (boundary) begin
            active_sel <= pending_sel;
            state      <= en ? ST_RUN : ST_OFF;
          end
        end
        // NOTE: default arm recovers from the unused encoding and keeps the case full.
        default: state <= ST_OFF;
      endcase
    end
  end

  clk_div_counter #(
    .SEL_W (SEL_W),
    .CNT_W (CNT_W)
  ) u_counter (
    .clk        (clk),
    .rst        (rst),
    .run        (busy),
    .active_sel (active_sel),
    .boundary   (boundary),
    .div_out    (div_out),
    .tick       (tick)
  );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a period-level model.
module tb_clk_div_ctrl;
  import clk_div_pkg::*;

  localparam int RST_SEL = 0;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             cfg_valid;
  logic [SEL_W-1:0] cfg_sel;
  logic             cfg_ready;
  logic [SEL_W-1:0] active_sel;
  logic             div_out;
  logic             tick;
  logic             busy;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: running/switching flags, position inside the period, ratios.
  bit m_on, m_sw;
  int m_pos, m_sel, m_pend;
  bit e_div, e_tick;

  always #5 clk = ~clk;

  clk_div_ctrl #(
    .SEL_W   (SEL_W),
    .CNT_W   (CNT_W),
    .RST_SEL (RST_SEL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .cfg_valid  (cfg_valid),
    .cfg_sel    (cfg_sel),
    .cfg_ready  (cfg_ready),
    .active_sel (active_sel),
    .div_out    (div_out),
    .tick       (tick),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Check all outputs at the falling edge, then drive inputs and advance the model.
  task automatic step(input bit r, input bit e, input bit v, input int s);
    int period;
    bit last;
    bit acc;
    @(negedge clk);
    check("busy",       32'(busy),       32'(m_on));
    check("cfg_ready",  32'(cfg_ready),  32'(!m_sw));
    check("active_sel", 32'(active_sel), 32'(m_sel));
    check("div_out",    32'(div_out),    32'(e_div));
    check("tick",       32'(tick),       32'(e_tick));
    rst       = r;
    en        = e;
    cfg_valid = v;
    cfg_sel   = SEL_W'(s);
    if (r) begin
      m_on = 0; m_sw = 0; m_pos = 0; m_sel = RST_SEL; m_pend = 0;
      e_div = 0; e_tick = 0;
    end else begin
      period = 2 << m_sel;
      last   = m_on && (m_pos == period - 1);
      acc    = v && !m_sw;
      e_tick = last;
      e_div  = (m_pos >= period / 2);
      if (!m_on) begin
        if (acc) m_sel = s;
        m_on  = e;
        m_pos = 0;
      end else begin
        m_pos = last ? 0 : m_pos + 1;
        if (m_sw) begin
          if (last) begin
            m_sel = m_pend;
            m_sw  = 0;
            m_on  = e;
          end
        end else if (acc) begin
          m_pend = s;
          m_sw   = 1;
        end else if (last && !e) begin
          m_on = 0;
        end
      end
    end
  endtask

  task automatic idle(input bit e, input int n);
    for (int i = 0; i < n; i++) step(0, e, 0, 0);
  endtask

  initial begin
    int sel_r;
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_sel = '0;
    m_on = 0; m_sw = 0; m_pos = 0; m_sel = RST_SEL; m_pend = 0; e_div = 0; e_tick = 0;
    repeat (2) @(posedge clk);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);

    // 1: start at /2
    idle(1, 10);

    // 2: offer sel=2 at count 0 while running /2
    for (int k = 0; k < 8 && !(m_on && !m_sw && m_pos == 0); k++) step(0, 1, 0, 0);
    check("t2_sync", 32'(m_on && !m_sw && m_pos == 0), 32'd1);
    step(0, 1, 1, 2);
    idle(1, 30);

    // 3: go to /16, drop en at count 5
    step(0, 1, 1, 3);
    for (int k = 0; k < 80 && !(m_sel == 3 && !m_sw && m_pos == 5); k++) step(0, 1, 0, 0);
    check("t3_sync", 32'(m_sel == 3 && m_pos == 5), 32'd1);
    idle(0, 20);
    check("t3_off", 32'(busy), 32'd0);

    // 4: configure in OFF, then run /64
    step(0, 0, 1, 5);
    idle(1, 140);

    // 5: reset while a switch to sel 4 is pending
    step(0, 1, 1, 4);
    idle(1, 2);
    step(1, 1, 0, 0);
    idle(0, 2);
    check("t5_sel", 32'(active_sel), 32'(RST_SEL));
    idle(1, 8);

    // 6: /256, cfg_valid held through SWITCH, exactly one transfer
    idle(0, 4);
    step(0, 0, 1, 7);
    idle(1, 10);
    step(0, 1, 1, 1);
    for (int k = 0; k < 400 && m_sw; k++) step(0, 1, 1, 1);
    check("t6_done", 32'(m_sw), 32'd0);
    idle(1, 20);
    check("t6_sel", 32'(active_sel), 32'd1);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      sel_r = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 2));
      step($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 15) == 0, sel_r);
    end
    step(0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
